// File: rtl/alu_issue_decode.sv
// alu_issue_decode
// Issue-side decode stage in front of the integer ALU. Takes RV32I words from
// fetch over a valid/ready handshake, decodes the OP and OP-IMM classes into
// the ALU operation code, register indices, operand-B immediate and write
// enable, and presents the result through a two-entry (output + skid)
// registered valid/ready buffer.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_flush             synchronous flush of both buffered entries
//   i_valid/o_ready     upstream handshake (o_ready is a flop output)
//   i_instr, i_pc       instruction word and its address
//   o_valid/i_ready     downstream handshake
//   o_pc                PC of the presented entry
//   o_alu_op            {qualifier, funct3} ALU operation code
//   o_rs1/o_rs2/o_rd    register indices
//   o_imm, o_use_imm    operand-B immediate and its select
//   o_rd_we, o_illegal  write-back enable, illegal-instruction flag
module alu_issue_decode #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [3:0]      o_alu_op,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic            o_use_imm,
    output logic            o_rd_we,
    output logic            o_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    entry_t     dec;

    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   ready_q;

    logic   accept;
    logic   consume;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // Combinational decode of the incoming word. Illegal words still produce
    // an entry, but with a neutral operation and no write-back.
    always_comb begin
        dec         = '0;
        legal       = 1'b0;
        dec.pc      = i_pc;
        dec.rs1     = i_instr[19:15];
        dec.rd      = i_instr[11:7];
        unique case (opcode)
            OPC_OP: begin
                dec.rs2 = i_instr[24:20];
                if (funct7 == F7_BASE) begin
                    legal      = 1'b1;
                    dec.alu_op = {1'b0, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal      = 1'b1;
                    dec.alu_op = {1'b1, funct3};
                end
            end
            OPC_OP_IMM: begin
                dec.use_imm = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: bits 31:25 select/qualify, shamt is zero-extended.
                    dec.imm = {{(XLEN-5){1'b0}}, i_instr[24:20]};
                    if (funct7 == F7_BASE) begin
                        legal      = 1'b1;
                        dec.alu_op = {1'b0, funct3};
                    end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                        legal      = 1'b1;
                        dec.alu_op = 4'b1101;
                    end
                end else begin
                    // Bit 30 is immediate data here, so the qualifier stays 0.
                    legal      = 1'b1;
                    dec.imm    = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                    dec.alu_op = {1'b0, funct3};
                end
            end
            default: ;
        endcase
        if (!legal) begin
            dec.illegal = 1'b1;
            dec.alu_op  = 4'b0000;
            dec.imm     = '0;
            dec.use_imm = 1'b0;
        end
        dec.rd_we = legal && (dec.rd != 5'd0);
    end

    // Handshake qualifiers; flush blocks any same-cycle accept.
    assign accept  = i_valid && ready_q && !i_flush;
    assign consume = out_valid_q && i_ready;

    // Output register plus skid register. The skid entry only fills when the
    // output register is held, and ready is recomputed from the next skid
    // occupancy so it stays a pure flop output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (i_flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (consume) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                ready_q      <= 1'b0;
            end
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = out_valid_q;
    assign o_pc      = out_q.pc;
    assign o_alu_op  = out_q.alu_op;
    assign o_rs1     = out_q.rs1;
    assign o_rs2     = out_q.rs2;
    assign o_rd      = out_q.rd;
    assign o_imm     = out_q.imm;
    assign o_use_imm = out_q.use_imm;
    assign o_rd_we   = out_q.rd_we;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// tb_alu_issue_decode
// Self-checking bench for alu_issue_decode. A queue-based reference model
// tracks the in-flight entries and the expected ready flag; every cycle the
// DUT outputs are compared against the head of that queue.
module tb_alu_issue_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_rd;
    logic [31:0] o_imm;
    logic        o_use_imm;
    logic        o_rd_we;
    logic        o_illegal;

    int   errors = 0;
    int   checks = 0;
    exp_t model_q[$];
    logic model_ready = 1'b1;
    logic last_accept = 1'b0;

    alu_issue_decode #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_instr  (i_instr),
        .i_pc     (i_pc),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_pc     (o_pc),
        .o_alu_op (o_alu_op),
        .o_rs1    (o_rs1),
        .o_rs2    (o_rs2),
        .o_rd     (o_rd),
        .o_imm    (o_imm),
        .o_use_imm(o_use_imm),
        .o_rd_we  (o_rd_we),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        int   opc;
        int   f3;
        int   f7;
        int   imm;
        bit   ok;
        opc   = int'(w[6:0]);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        ok    = 1'b0;
        e     = '0;
        e.pc  = p;
        e.rs1 = w[19:15];
        e.rd  = w[11:7];
        if (opc == 'h33) begin
            e.rs2 = w[24:20];
            if (f7 == 0) begin
                ok = 1'b1; e.alu_op = 4'(f3);
            end else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin
                ok = 1'b1; e.alu_op = 4'(8 + f3);
            end
        end else if (opc == 'h13) begin
            e.use_imm = 1'b1;
            if (f3 == 1 || f3 == 5) begin
                e.imm = 32'(int'(w[24:20]));
                if (f7 == 0) begin
                    ok = 1'b1; e.alu_op = 4'(f3);
                end else if (f3 == 5 && f7 == 32) begin
                    ok = 1'b1; e.alu_op = 4'd13;
                end
            end else begin
                imm = int'(w[31:20]);
                if (imm >= 2048) imm = imm - 4096;
                e.imm    = 32'(imm);
                e.alu_op = 4'(f3);
                ok       = 1'b1;
            end
        end
        if (!ok) begin
            e.illegal = 1'b1;
            e.alu_op  = 4'd0;
            e.imm     = 32'd0;
            e.use_imm = 1'b0;
            e.rd_we   = 1'b0;
        end else begin
            e.rd_we = (e.rd != 5'd0);
        end
        return e;
    endfunction

    task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares the DUT against the model; register indices of illegal
    // entries are left unchecked.
    task automatic checkOutput();
        exp_t obs;
        exp_t exp;
        check1("o_valid", 64'(o_valid), 64'(model_q.size() > 0));
        check1("o_ready", 64'(o_ready), 64'(model_ready));
        if (model_q.size() > 0) begin
            obs = '{o_pc, o_alu_op, o_rs1, o_rs2, o_rd, o_imm, o_use_imm, o_rd_we, o_illegal};
            exp = model_q[0];
            if (exp.illegal) begin
                obs.rs1 = '0; obs.rs2 = '0; obs.rd = '0;
                exp.rs1 = '0; exp.rs2 = '0; exp.rd = '0;
            end
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("[TB] FAIL entry: observed=%h expected=%h", obs, exp);
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model across the edge and
    // checks the outputs one time unit later.
    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] p,
                                 input logic rdy, input logic fl);
        logic consume;
        i_valid = v; i_instr = w; i_pc = p; i_ready = rdy; i_flush = fl;
        last_accept = 1'b0;
        if (fl) begin
            model_q.delete();
            model_ready = 1'b1;
        end else begin
            consume     = (model_q.size() > 0) && rdy;
            last_accept = v && model_ready;
            if (consume) void'(model_q.pop_front());
            if (last_accept) model_q.push_back(refDecode(w, p));
            model_ready = (model_q.size() < 2);
        end
        @(posedge i_clk);
        #1;
        checkOutput();
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = int'($urandom_range(0, 9));
        if (sel < 4)      w[6:0] = 7'b0110011;
        else if (sel < 8) w[6:0] = 7'b0010011;
        sel = int'($urandom_range(0, 3));
        if (sel == 0)      w[31:25] = 7'b0000000;
        else if (sel == 1) w[31:25] = 7'b0100000;
        return w;
    endfunction

    initial begin
        logic [31:0] words[4];
        int          acc;
        int          budget;
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_instr = '0; i_pc = '0; i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        $display("[TB] reset state");
        check1("rst_valid", 64'(o_valid), 64'd0);
        check1("rst_ready", 64'(o_ready), 64'd1);
        check1("rst_fields", 64'({o_pc, o_alu_op, o_rs1, o_rs2, o_rd} ^ {o_imm, o_use_imm, o_rd_we, o_illegal}), 64'd0);
        check1("rst_imm", 64'(o_imm), 64'd0);
        i_rst_n = 1'b1;

        $display("[TB] directed decode");
        applyStimulus(1, 32'h002081B3, 32'h100, 1, 0);
        check1("add_op", 64'(o_alu_op), 64'b0000);
        check1("add_regs", 64'({o_rs1, o_rs2, o_rd}), 64'({5'd1, 5'd2, 5'd3}));
        check1("add_flags", 64'({o_use_imm, o_rd_we, o_illegal}), 64'b010);
        applyStimulus(1, 32'h402081B3, 32'h104, 1, 0);
        check1("sub_op", 64'(o_alu_op), 64'b1000);
        applyStimulus(1, 32'h4033D313, 32'h108, 1, 0);
        check1("srai_op", 64'(o_alu_op), 64'b1101);
        check1("srai_imm", 64'(o_imm), 64'd3);
        check1("srai_fields", 64'({o_use_imm, o_rs1, o_rd}), 64'({1'b1, 5'd7, 5'd6}));
        applyStimulus(1, 32'hFFF00013, 32'h10C, 1, 0);
        check1("addi_x0_imm", 64'(o_imm), 64'hFFFFFFFF);
        check1("addi_x0_we", 64'({o_alu_op, o_rd_we}), 64'd0);
        applyStimulus(1, 32'hFFF00293, 32'h110, 1, 0);
        check1("addi_x5_we", 64'(o_rd_we), 64'd1);
        applyStimulus(1, 32'h022081B3, 32'h114, 1, 0);
        check1("mul_illegal", 64'({o_illegal, o_rd_we, o_alu_op}), 64'({1'b1, 1'b0, 4'd0}));
        applyStimulus(1, 32'h0000006F, 32'h118, 1, 0);
        check1("jal_illegal", 64'({o_illegal, o_rd_we, o_alu_op}), 64'({1'b1, 1'b0, 4'd0}));
        applyStimulus(1, 32'h40109093, 32'h11C, 1, 0);
        check1("slli_illegal", 64'({o_illegal, o_rd_we, o_alu_op}), 64'({1'b1, 1'b0, 4'd0}));
        applyStimulus(1, 32'h002081B3, 32'h120, 1, 0);
        check1("after_illegal", 64'({o_valid, o_illegal}), 64'b10);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        $display("[TB] backpressure");
        words[0] = 32'h00308133; words[1] = 32'h40315233;
        words[2] = 32'h00A28293; words[3] = 32'h0043F393;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, words[acc], 32'h200 + 32'(acc * 4), 0, 0);
            if (last_accept) acc++;
        end
        check1("bp_ready_low", 64'(o_ready), 64'd0);
        budget = 0;
        while (acc < 4 && budget < 12) begin
            applyStimulus(1, words[acc], 32'h200 + 32'(acc * 4), 1, 0);
            if (last_accept) acc++;
            budget++;
        end
        check1("bp_all_accepted", 64'(acc), 64'd4);
        repeat (3) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        $display("[TB] flush");
        applyStimulus(1, 32'h00110113, 32'h300, 0, 0);
        applyStimulus(1, 32'h00218193, 32'h304, 0, 0);
        check1("fl_full", 64'({o_valid, o_ready}), 64'b10);
        applyStimulus(1, 32'h00320213, 32'h308, 0, 1);
        check1("fl_after", 64'({o_valid, o_ready}), 64'b01);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        check1("fl_no_ghost", 64'(o_valid), 64'd0);

        $display("[TB] async reset mid-stream");
        applyStimulus(1, 32'h00110113, 32'h400, 0, 0);
        applyStimulus(1, 32'h00218193, 32'h404, 0, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check1("ar_valid", 64'(o_valid), 64'd0);
        check1("ar_ready", 64'(o_ready), 64'd1);
        check1("ar_pc", 64'(o_pc), 64'd0);
        model_q.delete();
        model_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0), randInstr(), $urandom,
                          logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 31) == 0));
        end
        repeat (4) applyStimulus(0, 32'h0, 32'h0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
